// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: steps the PWM pulse width toward a target in
// fixed-size increments, holding each intermediate value for a
// programmable number of extra cycles between steps.
module pwm_fade_ctrl #(
   parameter int unsigned CtrSize = 8,
   parameter int unsigned HoldW   = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [CtrSize-1:0] cmd_target_i,
   input  logic [CtrSize-1:0] cmd_step_i,
   input  logic [HoldW-1:0]   cmd_hold_i,
   input  logic [CtrSize-1:0] cmd_period_i,
   input  logic               abort_i,
   output logic [CtrSize-1:0] pulse_width_o,
   output logic [CtrSize-1:0] max_counter_o,
   output logic               busy_o,
   output logic               done_o
);

   typedef enum logic {
      IDLE,
      RAMP
   } state_t;

   state_t             state;
   logic [CtrSize-1:0] target;
   logic [CtrSize-1:0] step;
   logic [HoldW-1:0]   hold;
   logic [HoldW-1:0]   hold_cnt;
   logic [CtrSize-1:0] pulse_width;
   logic [CtrSize-1:0] max_counter;
   logic               done;

   logic               accept;
   logic [CtrSize-1:0] step_in;
   logic [CtrSize:0]   up_sum;
   logic [CtrSize-1:0] down_diff;
   logic [CtrSize-1:0] next_pw;

   assign cmd_ready_o   = (state == IDLE);
   assign busy_o        = (state == RAMP);
   assign done_o        = done;
   assign pulse_width_o = pulse_width;
   assign max_counter_o = max_counter;

   assign accept = cmd_valid_i && (state == IDLE);

   // A zero step would never reach the target, so it is promoted to 1.
   always_comb begin
      step_in = cmd_step_i;
      if (cmd_step_i == '0) begin
         step_in = CtrSize'(1);
      end
   end

   // Next pulse width for one step, clamped at the target in either
   // direction; the extra sum bit keeps an upward step from wrapping.
   always_comb begin
      up_sum    = {1'b0, pulse_width} + {1'b0, step};
      down_diff = pulse_width - step;
      next_pw   = pulse_width;
      if (target > pulse_width) begin
         if (up_sum >= {1'b0, target}) begin
            next_pw = target;
         end else begin
            next_pw = up_sum[CtrSize-1:0];
         end
      end else if (target < pulse_width) begin
         if ((pulse_width < step) || (down_diff < target)) begin
            next_pw = target;
         end else begin
            next_pw = down_diff;
         end
      end
   end

   // Command acceptance, hold counting, stepping and abort handling.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         target      <= '0;
         step        <= '0;
         hold        <= '0;
         hold_cnt    <= '0;
         pulse_width <= '0;
         max_counter <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  target      <= cmd_target_i;
                  step        <= step_in;
                  hold        <= cmd_hold_i;
                  max_counter <= cmd_period_i;
                  hold_cnt    <= '0;
                  if (cmd_target_i == pulse_width) begin
                     done <= 1'b1;
                  end else begin
                     state <= RAMP;
                  end
               end
            end
            RAMP: begin
               if (abort_i) begin
                  state    <= IDLE;
                  hold_cnt <= '0;
               end else if (hold_cnt < hold) begin
                  hold_cnt <= hold_cnt + HoldW'(1);
               end else begin
                  hold_cnt    <= '0;
                  pulse_width <= next_pw;
                  if (next_pw == target) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl (CtrSize=8, HoldW=16).
module tb_pwm_fade_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_target;
   logic [7:0]  cmd_step;
   logic [15:0] cmd_hold;
   logic [7:0]  cmd_period;
   logic        abort;
   logic [7:0]  pulse_width;
   logic [7:0]  max_counter;
   logic        busy;
   logic        done;

   int unsigned checks = 0;
   int unsigned errors = 0;

   pwm_fade_ctrl #(
      .CtrSize(8),
      .HoldW  (16)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_target_i (cmd_target),
      .cmd_step_i   (cmd_step),
      .cmd_hold_i   (cmd_hold),
      .cmd_period_i (cmd_period),
      .abort_i      (abort),
      .pulse_width_o(pulse_width),
      .max_counter_o(max_counter),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then land on the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [7:0] t, input logic [7:0] s,
                        input logic [15:0] h, input logic [7:0] p);
      cmd_valid  = 1'b1;
      cmd_target = t;
      cmd_step   = s;
      cmd_hold   = h;
      cmd_period = p;
      tick();
      cmd_valid  = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_target = '0;
      cmd_step   = '0;
      cmd_hold   = '0;
      cmd_period = '0;
      abort      = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_pw",    32'(pulse_width), 0);
      chk("rst_max",   32'(max_counter), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      rst_n = 1'b1;
      tick();

      // Ramp 0 -> 10, step 3, hold 1, period 20
      issue(8'd10, 8'd3, 16'd1, 8'd20);           // edge k
      chk("r1_max_k",   32'(max_counter), 20);
      chk("r1_busy_k",  32'(busy), 1);
      chk("r1_ready_k", 32'(cmd_ready), 0);
      chk("r1_pw_k",    32'(pulse_width), 0);
      tick();                                      // k+1
      chk("r1_pw_k1",   32'(pulse_width), 0);
      tick();                                      // k+2
      chk("r1_pw_k2",   32'(pulse_width), 3);
      tick();
      chk("r1_pw_k3",   32'(pulse_width), 3);
      tick();                                      // k+4
      chk("r1_pw_k4",   32'(pulse_width), 6);
      tick();
      tick();                                      // k+6
      chk("r1_pw_k6",   32'(pulse_width), 9);
      tick();                                      // k+7
      chk("r1_done_k7", 32'(done), 0);
      chk("r1_busy_k7", 32'(busy), 1);
      tick();                                      // k+8
      chk("r1_pw_k8",   32'(pulse_width), 10);
      chk("r1_done_k8", 32'(done), 1);
      chk("r1_busy_k8", 32'(busy), 0);
      tick();
      chk("r1_done_k9", 32'(done), 0);

      // Target equal to current width: done without RAMP
      issue(8'd10, 8'd4, 16'd2, 8'd30);
      chk("eq_busy",  32'(busy), 0);
      chk("eq_done",  32'(done), 1);
      chk("eq_max",   32'(max_counter), 30);
      tick();
      chk("eq_done2", 32'(done), 0);

      // Jump to 200 (step larger than needed clamps at target)
      issue(8'd200, 8'd255, 16'd0, 8'd255);
      tick();
      chk("up200_pw",   32'(pulse_width), 200);
      chk("up200_done", 32'(done), 1);
      tick();

      // 200 -> 5, step 100, hold 0
      issue(8'd5, 8'd100, 16'd0, 8'd255);
      tick();
      chk("dn_pw1",   32'(pulse_width), 100);
      chk("dn_busy1", 32'(busy), 1);
      tick();
      chk("dn_pw2",   32'(pulse_width), 5);
      chk("dn_done",  32'(done), 1);
      chk("dn_busy2", 32'(busy), 0);

      // 5 -> 250 in one step, then 250 -> 255 with step 10 (no wrap)
      issue(8'd250, 8'd245, 16'd0, 8'd255);
      tick();
      chk("to250_pw", 32'(pulse_width), 250);
      issue(8'd255, 8'd10, 16'd0, 8'd255);
      tick();
      chk("nowrap_pw",   32'(pulse_width), 255);
      chk("nowrap_done", 32'(done), 1);

      // Back to 250, then step=0 acts as step 1 up to 253
      issue(8'd250, 8'd5, 16'd0, 8'd255);
      tick();
      chk("back250_pw", 32'(pulse_width), 250);
      issue(8'd253, 8'd0, 16'd0, 8'd255);
      tick();
      chk("s0_pw1", 32'(pulse_width), 251);
      tick();
      chk("s0_pw2", 32'(pulse_width), 252);
      tick();
      chk("s0_pw3",  32'(pulse_width), 253);
      chk("s0_done", 32'(done), 1);

      // Downward step larger than current width: no underflow
      issue(8'd3, 8'd255, 16'd0, 8'd255);
      tick();
      chk("uf_pw",   32'(pulse_width), 3);
      chk("uf_done", 32'(done), 1);

      // Abort mid-fade at pw=6, abort beats the pending step
      issue(8'd30, 8'd3, 16'd0, 8'd40);
      tick();
      chk("ab_pw_pre", 32'(pulse_width), 6);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_pw",    32'(pulse_width), 6);
      chk("ab_busy",  32'(busy), 0);
      chk("ab_done",  32'(done), 0);
      chk("ab_ready", 32'(cmd_ready), 1);
      chk("ab_max",   32'(max_counter), 40);
      tick();
      chk("ab_pw2",   32'(pulse_width), 6);
      chk("ab_done2", 32'(done), 0);

      // abort_i in IDLE is ignored; command still accepted
      abort = 1'b1;
      issue(8'd8, 8'd2, 16'd0, 8'd50);
      abort = 1'b0;
      chk("ai_busy", 32'(busy), 1);
      chk("ai_max",  32'(max_counter), 50);
      tick();
      chk("ai_pw",   32'(pulse_width), 8);
      chk("ai_done", 32'(done), 1);

      // Asynchronous reset mid-RAMP
      issue(8'd100, 8'd1, 16'd3, 8'd99);
      tick();
      chk("rr_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rr_pw",    32'(pulse_width), 0);
      chk("rr_max",   32'(max_counter), 0);
      chk("rr_busy0", 32'(busy), 0);
      chk("rr_done",  32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rr_ready", 32'(cmd_ready), 1);
      chk("rr_busy1", 32'(busy), 0);
      chk("rr_done1", 32'(done), 0);
      tick();
      chk("rr_pw1",   32'(pulse_width), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
